// File: rtl/mips_pkg.sv
// Shared MIPS types for the memory arbiter.
// Holds the default memory geometry, the arbiter FSM state type and the
// access-owner type.
package mips_pkg;

  localparam int unsigned MEM_ADDR_W = 10;  // 1024-word unified memory
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the memory.
// Requester side: if_req/if_addr -> if_ack/if_rdata (fetch),
//                 d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata (data).
// Memory side:    mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata.
// slave  : arbiter view.  master : pipeline core + memory view.
interface mips_mem_arbiter_if #(
  parameter int unsigned ADDR_W = mips_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = mips_pkg::WORD_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port synchronous memory between the IF and MEM stages.
// Each access runs IDLE/RESP (arbitrate) -> ISSUE (strobe memory) -> RESP
// (ack + return data). Data port wins over fetch; the port just served is
// masked in RESP so the two ports alternate under contention. halt blocks
// new fetch grants only.
// Ports: clk1, rst_n (sync, active-low), halt, busy, bus (slave modport).
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = WORD_W
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                halt,
  output logic                busy,
  mips_mem_arbiter_if.slave   bus
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;

  logic in_resp_c;
  logic d_elig_c;
  logic if_elig_c;

  // Masked priority pick: the owner being acked this cycle cannot re-win.
  always_comb begin
    in_resp_c = (state_q == ARB_RESP);
    d_elig_c  = bus.d_req && !(in_resp_c && owner_q == OWN_D);
    if_elig_c = bus.if_req && !halt && !(in_resp_c && owner_q == OWN_IF);
  end

  // Next-state, request latch and hold-register update.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    if_hold_d = if_hold_q;
    d_hold_d  = d_hold_q;

    if (state_q == ARB_RESP) begin
      if (owner_q == OWN_D) d_hold_d = bus.mem_rdata;
      else                  if_hold_d = bus.mem_rdata;
    end

    case (state_q)
      ARB_IDLE, ARB_RESP: begin
        if (d_elig_c) begin
          owner_d = OWN_D;
          addr_d  = bus.d_addr;
          we_d    = bus.d_we;
          wdata_d = bus.d_wdata;
          state_d = ARB_ISSUE;
        end else if (if_elig_c) begin
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          state_d = ARB_ISSUE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: state_d = ARB_RESP;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

  // Memory strobes, acks and busy decode straight from flops.
  assign bus.mem_en    = (state_q == ARB_ISSUE);
  assign bus.mem_we    = (state_q == ARB_ISSUE) && (owner_q == OWN_D) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = (state_q == ARB_RESP) && (owner_q == OWN_IF);
  assign bus.d_ack     = (state_q == ARB_RESP) && (owner_q == OWN_D);
  assign busy          = (state_q != ARB_IDLE);

  // Read data bypasses the hold register in the ack cycle.
  assign bus.if_rdata = bus.if_ack ? bus.mem_rdata : if_hold_q;
  assign bus.d_rdata  = bus.d_ack  ? bus.mem_rdata : d_hold_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed steps followed by a
// randomized two-requester phase scored against a word-array memory image.
module tb_mips_mem_arbiter;
  import mips_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk1 = 1'b0;
  logic rst_n;
  logic halt;
  logic busy;

  always #5 clk1 = ~clk1;

  mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .halt  (halt),
    .busy  (busy),
    .bus   (bus)
  );

  // Synchronous single-port memory with a preload port for the bench.
  logic [DW-1:0] mem [1024];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk1) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // Expected memory contents, updated in access-completion order.
  logic [DW-1:0] ref_mem [1024];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = v;
    ref_mem[a] = v;
    step();
    pre_we = 1'b0;
  endtask

  // One complete data access with a bounded wait for d_ack.
  task automatic d_access(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input string tag);
    int   n   = 0;
    logic got = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    while (!got && n < 10) begin
      step();
      n++;
      if (bus.d_ack) got = 1'b1;
    end
    chk({tag, "_ack"}, DW'(got), 32'h1);
    if (got) begin
      chk({tag, "_noifack"}, DW'(bus.if_ack), 32'h0);
      if (we) ref_mem[a] = wd;
      else    chk({tag, "_data"}, bus.d_rdata, ref_mem[a]);
    end
    bus.d_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          dp, d_wer, ip;
    logic [AW-1:0] d_ar, i_ar;
    logic [DW-1:0] d_wdr;
    int            d_wait, i_wait;

    rst_n       = 1'b0;
    halt        = 1'b0;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    step();

    for (int i = 0; i < 1024; i++) preload(AW'(i), DW'($urandom));
    preload(AW'(0), 32'h2801000a);
    preload(AW'(1), 32'h28020014);
    preload(AW'(5), 32'h00222000);

    // Reset held two cycles with both requests up.
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = AW'(3);
    step();
    step();
    chk("rst_if_ack",    DW'(bus.if_ack),   32'h0);
    chk("rst_d_ack",     DW'(bus.d_ack),    32'h0);
    chk("rst_mem_en",    DW'(bus.mem_en),   32'h0);
    chk("rst_mem_we",    DW'(bus.mem_we),   32'h0);
    chk("rst_mem_addr",  DW'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata,     32'h0);
    chk("rst_if_rdata",  bus.if_rdata,      32'h0);
    chk("rst_d_rdata",   bus.d_rdata,       32'h0);
    chk("rst_busy",      DW'(busy),         32'h0);

    // Release: one IDLE cycle, then the data load issues.
    rst_n      = 1'b1;
    bus.if_req = 1'b0;
    step();
    chk("rel_mem_en",   DW'(bus.mem_en),   32'h1);
    chk("rel_mem_addr", DW'(bus.mem_addr), 32'h3);
    chk("rel_busy",     DW'(busy),         32'h1);
    step();
    chk("rel_d_ack",   DW'(bus.d_ack), 32'h1);
    chk("rel_d_rdata", bus.d_rdata,    ref_mem[3]);
    bus.d_req = 1'b0;
    step();
    chk("rel_idle_busy", DW'(busy), 32'h0);

    // Single fetch.
    bus.if_req  = 1'b1;
    bus.if_addr = AW'(0);
    step();
    chk("if_mem_en",   DW'(bus.mem_en),   32'h1);
    chk("if_mem_addr", DW'(bus.mem_addr), 32'h0);
    chk("if_mem_we",   DW'(bus.mem_we),   32'h0);
    step();
    chk("if_ack",   DW'(bus.if_ack), 32'h1);
    chk("if_rdata", bus.if_rdata,    32'h2801000a);
    bus.if_req = 1'b0;
    step();
    chk("if_ack_one_cycle", DW'(bus.if_ack), 32'h0);
    step();
    step();
    chk("if_rdata_hold", bus.if_rdata, 32'h2801000a);

    // Contention: data first, then fetch.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = AW'(5);
    bus.if_req  = 1'b1;
    bus.if_addr = AW'(1);
    step();
    chk("ct_mem_addr_d", DW'(bus.mem_addr), 32'h5);
    step();
    chk("ct_d_ack",   DW'(bus.d_ack),  32'h1);
    chk("ct_if_wait", DW'(bus.if_ack), 32'h0);
    chk("ct_d_rdata", bus.d_rdata,     32'h00222000);
    bus.d_req = 1'b0;
    step();
    chk("ct_mem_en_if",   DW'(bus.mem_en),   32'h1);
    chk("ct_mem_addr_if", DW'(bus.mem_addr), 32'h1);
    step();
    chk("ct_if_ack",   DW'(bus.if_ack), 32'h1);
    chk("ct_if_rdata", bus.if_rdata,    32'h28020014);
    bus.if_req = 1'b0;
    step();

    // Store, then read it back.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = AW'(7);
    bus.d_wdata = 32'h00832800;
    step();
    chk("st_mem_we",    DW'(bus.mem_we),   32'h1);
    chk("st_mem_addr",  DW'(bus.mem_addr), 32'h7);
    chk("st_mem_wdata", bus.mem_wdata,     32'h00832800);
    step();
    chk("st_d_ack", DW'(bus.d_ack), 32'h1);
    ref_mem[7] = 32'h00832800;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    step();
    d_access(1'b0, AW'(7), 32'h0, "ld7");

    // Halt blocks fetch grants; a data access still goes through.
    halt        = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = AW'(2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_no_mem_en_a", DW'(bus.mem_en), 32'h0);
    end
    d_access(1'b0, AW'(5), 32'h0, "halt_ld");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_no_mem_en_b", DW'(bus.mem_en), 32'h0);
      chk("halt_no_if_ack",   DW'(bus.if_ack), 32'h0);
    end
    halt = 1'b0;
    step();
    chk("unhalt_mem_en",   DW'(bus.mem_en),   32'h1);
    chk("unhalt_mem_addr", DW'(bus.mem_addr), 32'h2);
    step();
    chk("unhalt_if_ack",   DW'(bus.if_ack), 32'h1);
    chk("unhalt_if_rdata", bus.if_rdata,    ref_mem[2]);
    bus.if_req = 1'b0;
    step();

    // Reset during the ISSUE cycle of a fetch.
    bus.if_req  = 1'b1;
    bus.if_addr = AW'(0);
    step();
    chk("mid_issue", DW'(bus.mem_en), 32'h1);
    rst_n = 1'b0;
    step();
    chk("mid_mem_en",   DW'(bus.mem_en), 32'h0);
    chk("mid_if_ack",   DW'(bus.if_ack), 32'h0);
    chk("mid_busy",     DW'(busy),       32'h0);
    chk("mid_if_rdata", bus.if_rdata,    32'h0);
    bus.if_req = 1'b0;
    rst_n      = 1'b1;
    step();

    // Randomized traffic on both ports.
    dp = 1'b0; ip = 1'b0; d_wer = 1'b0;
    d_ar = '0; i_ar = '0; d_wdr = '0;
    d_wait = 0; i_wait = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (bus.if_ack || bus.d_ack)
        chk("rnd_single_ack", DW'(bus.if_ack & bus.d_ack), 32'h0);
      if (bus.mem_en && bus.mem_we) begin
        chk("rnd_st_owner", DW'(dp && d_wer), 32'h1);
        chk("rnd_st_addr",  DW'(bus.mem_addr), DW'(d_ar));
        chk("rnd_st_data",  bus.mem_wdata, d_wdr);
      end

      if (dp) begin
        if (bus.d_ack) begin
          if (d_wer) ref_mem[d_ar] = d_wdr;
          else       chk("rnd_d_rdata", bus.d_rdata, ref_mem[d_ar]);
          dp = 1'b0;
          bus.d_req = 1'b0;
        end else begin
          d_wait++;
          if (d_wait > 8) begin
            chk("rnd_d_latency", DW'(d_wait), 32'h8);
            dp = 1'b0;
            bus.d_req = 1'b0;
          end
        end
      end else begin
        chk("rnd_d_spurious", DW'(bus.d_ack), 32'h0);
        if ($urandom_range(1, 0) == 1) begin
          dp     = 1'b1;
          d_wait = 0;
          d_wer  = ($urandom_range(1, 0) == 1);
          d_ar   = AW'($urandom_range(15, 0));
          d_wdr  = DW'($urandom);
          bus.d_req   = 1'b1;
          bus.d_we    = d_wer;
          bus.d_addr  = d_ar;
          bus.d_wdata = d_wdr;
        end
      end

      if (ip) begin
        if (bus.if_ack) begin
          chk("rnd_if_rdata", bus.if_rdata, ref_mem[i_ar]);
          ip = 1'b0;
          bus.if_req = 1'b0;
        end else begin
          i_wait++;
          if (i_wait > 8) begin
            chk("rnd_if_latency", DW'(i_wait), 32'h8);
            ip = 1'b0;
            bus.if_req = 1'b0;
          end
        end
      end else begin
        chk("rnd_if_spurious", DW'(bus.if_ack), 32'h0);
        if ($urandom_range(1, 0) == 1) begin
          ip     = 1'b1;
          i_wait = 0;
          i_ar   = AW'($urandom_range(15, 0));
          bus.if_req  = 1'b1;
          bus.if_addr = i_ar;
        end
      end

      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-clock arbiter that shares one single-port synchronous memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the MIPS pipeline. It sequences each access through issue and response phases and routes the read data back to the winner. It also gates new fetches while the processor is halted. It sits between the pipeline core and the unified `Mem` array.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width (1024-word memory)
- `DATA_W`, 32, data word width

Ports:
- `clk1`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ack`
- `if_addr`  in  ADDR_W  fetch word address
- `if_ack`  out  1  one-cycle fetch completion
- `if_rdata`  out  DATA_W  fetched word; valid with `if_ack`, held afterwards
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data word address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle data completion
- `d_rdata`  out  DATA_W  load data; valid with `d_ack`, held afterwards
- `halt`  in  1  blocks new IF grants; data accesses continue
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en`
- `busy`  out  1  state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP. Owner flop: IF or D.
- IDLE: arbitrate.
  - If any request is eligible, latch owner, address, we and wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Drive `mem_en`=1 from the latched registers.
  - Drive `mem_we` = latched we when owner is D, otherwise 0.
  - Unconditionally go to RESP.
- RESP:
  - Assert the owner's ack and drive its rdata = `mem_rdata`.
  - Load the owner's hold register with `mem_rdata`. On a store, `d_rdata` = `mem_rdata` (content unspecified).
  - Arbitrate again, ignoring the owner's req this cycle. If a winner exists, go to ISSUE; otherwise go to IDLE.
- Arbitration:
  - `d_req` beats `if_req`.
  - `if_req` is eligible only when `halt`=0.
  - Masking the served port in RESP makes both ports alternate under contention.
- Rdata outputs: in the ack cycle, rdata = `mem_rdata`; otherwise rdata = hold register.
- Addresses pass through unchanged at ADDR_W bits. Requesters truncate; there is no wrap logic.
- `halt` rising while an IF access is in ISSUE or RESP does not cancel it; that access completes normally.

## Timing
- Reset values: `if_ack`=`d_ack`=0, `mem_en`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0, hold registers 0 (so `if_rdata`=`d_rdata`=0), `busy`=0, state IDLE.
- `rst_n` low at any edge, including mid-access: next cycle is IDLE with all outputs at reset values. The in-flight access is abandoned without ack; a store already issued stays written.
- Latency from IDLE: req seen in cycle T, `mem_en` in T+1, ack in T+2.
- Back-to-back with both ports requesting: ISSUE/RESP alternate, one access per 2 cycles.
- Single port streaming (req held after ack): 3 cycles per access, because the port is masked in RESP.
- Ack is exactly one cycle per access. Requesters change address/data only after sampling ack.
- `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, ack and `busy` are decoded from flops only, with no combinational path from req. rdata is the only combinational path, `mem_rdata` → rdata.

## Structure
- Shared package `mips_pkg` holds:
  - `MEM_ADDR_W`/`WORD_W` constants, used as parameter defaults;
  - FSM state typedef (ARB_IDLE, ARB_ISSUE, ARB_RESP);
  - owner typedef (OWN_IF, OWN_D).
- Single flat module; the 2-input masked priority pick is inline, so no sub-module.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with both reqs high → all outputs 0, `busy`=0. After release, first `mem_en` appears 2 cycles later (1 cycle in IDLE, then ISSUE).
- IF read: Mem[0]=32'h2801000a, `if_req`=1, `if_addr`=0 at T → `mem_en`=1, `mem_addr`=0, `mem_we`=0 at T+1; `if_ack`=1, `if_rdata`=32'h2801000a at T+2; `if_rdata` still 32'h2801000a at T+5.
- Contention: `d_req` load addr 5 (Mem[5]=32'h00222000) and `if_req` addr 1 (Mem[1]=32'h28020014) both at T, held until ack → `d_ack` at T+2 with 32'h00222000; `mem_addr`=1 at T+3; `if_ack` at T+4 with 32'h28020014.
- Store: `d_we`=1, addr 7, `d_wdata`=32'h00832800 → `mem_we`=1 at T+1, `d_ack` at T+2; a following load of addr 7 returns 32'h00832800.
- Halt: `halt`=1 with `if_req` held for 10 cycles → no `mem_en` for IF. A `d_req` in that window is acked normally. After `halt`=0 in cycle H → IF `mem_en` at H+1.
- Reset mid-op: `rst_n`=0 in the ISSUE cycle of an IF read → next cycle `mem_en`=0, no `if_ack`, `busy`=0, `if_rdata`=0.
